// File: rtl/spart_brg_pkg.sv
// Shared SPART definitions, used by the baud rate generator, receive,
// transmit and the bus interface.
//   ioaddr_e   : register select encodings on the SPART I/O bus
//   DIV_W      : baud divisor width, made of two bus bytes
//   OVERSAMPLE : receive sample enables per transmit bit enable (power of 2)
//   PHASE_W    : width of the oversample phase counter
package spart_pkg;

  localparam int DIV_W      = 16;
  localparam int OVERSAMPLE = 16;
  localparam int PHASE_W    = $clog2(OVERSAMPLE);

  typedef enum logic [1:0] {
    ADDR_RXTX   = 2'b00,
    ADDR_STATUS = 2'b01,
    ADDR_DB_LO  = 2'b10,
    ADDR_DB_HI  = 2'b11
  } ioaddr_e;

endpackage

// File: rtl/spart_brg_if.sv
// SPART I/O bus as seen by the baud rate generator.
//   iocs       : chip select
//   iorw       : 1 = read, 0 = write
//   ioaddr     : register select
//   databus_wr : write data byte
// master : bus interface side (drives)
// slave  : baud rate generator side (samples)
interface spart_brg_if;
  logic       iocs;
  logic       iorw;
  logic [1:0] ioaddr;
  logic [7:0] databus_wr;

  modport master (output iocs, output iorw, output ioaddr, output databus_wr);
  modport slave  (input  iocs, input  iorw, input  ioaddr, input  databus_wr);
endinterface

// File: rtl/spart_brg.sv
// SPART baud rate generator.
// Produces one-clock enables for the receive block (brg_rx_en, every
// active_div+1 clocks) and the transmit block (brg_tx_en, on every
// OVERSAMPLE-th brg_rx_en). The divisor is loaded as a low byte (staged)
// followed by a high byte, which commits the divisor and restarts timing.
//   clk       : system clock
//   rst_n     : asynchronous active-low reset
//   bus       : SPART I/O bus (slave modport)
//   brg_rx_en : 16x baud sample enable
//   brg_tx_en : 1x baud bit enable
module spart_brg
  import spart_pkg::*;
#(
  parameter logic [DIV_W-1:0] DEFAULT_DIV = 16'd31
) (
  input  logic        clk,
  input  logic        rst_n,
  spart_brg_if.slave  bus,
  output logic        brg_rx_en,
  output logic        brg_tx_en
);

  logic [DIV_W-1:0]   active_div;
  logic [DIV_W-1:0]   count;
  logic [7:0]         lo_stage;
  logic [PHASE_W-1:0] phase;

  logic             wr_lo;
  logic             wr_hi;
  logic [DIV_W-1:0] new_div;

  assign wr_lo   = bus.iocs & ~bus.iorw & (bus.ioaddr == ADDR_DB_LO);
  assign wr_hi   = bus.iocs & ~bus.iorw & (bus.ioaddr == ADDR_DB_HI);
  assign new_div = {bus.databus_wr, lo_stage};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_div <= DEFAULT_DIV;
      lo_stage   <= DEFAULT_DIV[7:0];
      count      <= DEFAULT_DIV;
      phase      <= '0;
      brg_rx_en  <= 1'b0;
      brg_tx_en  <= 1'b0;
    end else begin
      // lo_stage is only a staging byte; it survives commits so a lone
      // high-byte write reuses the previous low byte.
      if (wr_lo) begin
        lo_stage <= bus.databus_wr;
      end

      if (wr_hi) begin
        // Commit restarts the period; any pulse due this edge is dropped.
        active_div <= new_div;
        count      <= new_div;
        phase      <= '0;
        brg_rx_en  <= 1'b0;
        brg_tx_en  <= 1'b0;
      end else if (count != '0) begin
        count     <= count - DIV_W'(1);
        brg_rx_en <= 1'b0;
        brg_tx_en <= 1'b0;
      end else begin
        // Terminal count: reload and emit. Phase wraps naturally at
        // OVERSAMPLE because its width is log2(OVERSAMPLE).
        count     <= active_div;
        brg_rx_en <= 1'b1;
        brg_tx_en <= (phase == PHASE_W'(OVERSAMPLE - 1));
        phase     <= phase + PHASE_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_spart_brg.sv
module tb_spart_brg;
  import spart_pkg::*;

  logic clk;
  logic rst_n;
  logic brg_rx_en;
  logic brg_tx_en;

  spart_brg_if bus ();

  spart_brg dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .brg_rx_en (brg_rx_en),
    .brg_tx_en (brg_tx_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: timing is a pure function of edges since the last
  // restart (reset release or commit) and the committed divisor.
  int         m_div;
  logic [7:0] m_lo;
  int         m_k;
  int         rx_seen;
  int         tx_seen;

  function automatic void check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic int exp_rx();
    return (m_k > 0 && (m_k % (m_div + 1)) == 0) ? 1 : 0;
  endfunction

  function automatic int exp_tx();
    return (m_k > 0 && (m_k % (OVERSAMPLE * (m_div + 1))) == 0) ? 1 : 0;
  endfunction

  // Called at a negedge: drive bus, take one rising edge, update the
  // model, then sample at the following negedge.
  task automatic cycle(input logic cs, input logic rw, input logic [1:0] a,
                       input logic [7:0] d);
    bus.iocs       = cs;
    bus.iorw       = rw;
    bus.ioaddr     = a;
    bus.databus_wr = d;
    @(posedge clk);
    if (cs && !rw && a == ADDR_DB_HI) begin
      m_div = {d, m_lo};
      m_k   = 0;
    end else begin
      m_k++;
    end
    if (cs && !rw && a == ADDR_DB_LO) m_lo = d;
    @(negedge clk);
    check("rx_model", int'(brg_rx_en), exp_rx());
    check("tx_model", int'(brg_tx_en), exp_tx());
    if (brg_rx_en) rx_seen++;
    if (brg_tx_en) tx_seen++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 2'b00, 8'h00);
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    cycle(1'b1, 1'b0, a, d);
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    bus.iocs       = 1'b0;
    bus.iorw       = 1'b0;
    bus.ioaddr     = 2'b00;
    bus.databus_wr = 8'h00;
    m_div = 31;
    m_lo  = 8'h1F;
    m_k   = 0;
    @(negedge clk);
    @(negedge clk);
    check("reset_rx", int'(brg_rx_en), 0);
    check("reset_tx", int'(brg_tx_en), 0);
    rst_n = 1'b1;
  endtask

  // Cycles from the commit edge to the first brg_rx_en, bounded.
  task automatic measure_first(input int limit, output int period);
    period = -1;
    for (int i = 1; i <= limit; i++) begin
      idle(1);
      if (brg_rx_en) begin
        period = i;
        break;
      end
    end
  endtask

  typedef struct {
    logic       cs;
    logic       rw;
    logic [1:0] addr;
    logic [7:0] data;
    int         exp_period;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int p;
    int r;
    logic [1:0] ra;

    vecs[0] = '{1'b1, 1'b0, 2'b10, 8'h05, 6};
    vecs[1] = '{1'b1, 1'b1, 2'b10, 8'h09, 6};
    vecs[2] = '{1'b0, 1'b0, 2'b10, 8'h0A, 6};
    vecs[3] = '{1'b1, 1'b0, 2'b00, 8'h0B, 6};
    vecs[4] = '{1'b1, 1'b0, 2'b01, 8'h0C, 6};
    vecs[5] = '{1'b1, 1'b0, 2'b10, 8'h03, 4};
    vecs[6] = '{1'b1, 1'b1, 2'b11, 8'h02, 4};

    do_reset();

    // Default divisor 31: rx every 32, tx every 512.
    rx_seen = 0; tx_seen = 0;
    idle(1100);
    check("default_rx_count", rx_seen, 34);
    check("default_tx_count", tx_seen, 2);

    // Divisor 325 committed; phase restarts.
    wr(ADDR_DB_LO, 8'h45);
    wr(ADDR_DB_HI, 8'h01);
    rx_seen = 0; tx_seen = 0;
    idle(16 * 326);
    check("div325_rx_count", rx_seen, 16);
    check("div325_tx_count", tx_seen, 1);
    check("div325_tx_last", int'(brg_tx_en), 1);

    // Low byte alone does not change timing; commit of 0 gives period 8.
    do_reset();
    wr(ADDR_DB_LO, 8'h07);
    rx_seen = 0;
    idle(95);
    check("lo_only_rx_count", rx_seen, 3);
    wr(ADDR_DB_HI, 8'h00);
    measure_first(100, p);
    check("div7_period", p, 8);

    // Decode table: each op followed by a commit of high byte 0.
    foreach (vecs[i]) begin
      cycle(vecs[i].cs, vecs[i].rw, vecs[i].addr, vecs[i].data);
      wr(ADDR_DB_HI, 8'h00);
      measure_first(300, p);
      check($sformatf("decode_vec%0d_period", i), p, vecs[i].exp_period);
    end

    // Commit on the terminal-count cycle suppresses that pulse.
    wr(ADDR_DB_LO, 8'h07);
    wr(ADDR_DB_HI, 8'h00);
    measure_first(100, p);
    idle(7);
    wr(ADDR_DB_HI, 8'h00);
    check("commit_at_tc_rx", int'(brg_rx_en), 0);
    measure_first(100, p);
    check("commit_at_tc_period", p, 8);

    // Divisor 0: rx every cycle, tx one cycle in 16.
    wr(ADDR_DB_LO, 8'h00);
    wr(ADDR_DB_HI, 8'h00);
    rx_seen = 0; tx_seen = 0;
    idle(40);
    check("div0_rx_count", rx_seen, 40);
    check("div0_tx_count", tx_seen, 2);

    // Reset during a pulse drops outputs asynchronously.
    idle(15);
    check("pre_reset_rx", int'(brg_rx_en), 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_drop_rx", int'(brg_rx_en), 0);
    check("async_drop_tx", int'(brg_tx_en), 0);
    do_reset();
    measure_first(100, p);
    check("post_reset_period", p, 32);
    wr(ADDR_DB_HI, 8'h00);
    measure_first(100, p);
    check("post_reset_lo_stage_period", p, 32);

    // Randomized bus traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 4) begin
        ra = 2'($urandom_range(0, 3));
        cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ra,
              (ra == ADDR_DB_HI) ? 8'($urandom_range(0, 1)) : 8'($urandom));
      end else begin
        idle(1);
      end
    end

    // Maximum divisor: period 65536 without overflow.
    wr(ADDR_DB_LO, 8'hFF);
    wr(ADDR_DB_HI, 8'hFF);
    rx_seen = 0;
    idle(65536);
    check("divmax_rx_count", rx_seen, 1);
    check("divmax_rx_last", int'(brg_rx_en), 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/spart_brg.md
Name: spart_brg

Overview:
Baud rate generator for the SPART. It sits directly upstream of the receive block and the transmit block, and drives their one-cycle sampling enables: brg_rx_en at 16x baud and brg_tx_en at 1x baud. The 16-bit divisor is programmed by the processor over the SPART I/O bus as two byte writes (low, then high). The high-byte write commits the new divisor and restarts the timing phase.

Parameters:
DIV_W, 16, divisor width; fixed at 2 x 8-bit bus bytes.
DEFAULT_DIV, 16'd31, active divisor after reset. Gives a brg_rx_en period of 32 clocks.
OVERSAMPLE, 16, brg_rx_en pulses per brg_tx_en pulse; must be a power of 2.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
iocs  input  1  I/O chip select for the SPART
iorw  input  1  1 = read, 0 = write
ioaddr  input  2  register select; 2'b10 = divisor low byte (DB_LO), 2'b11 = divisor high byte (DB_HI)
databus_wr  input  8  write data from the bus interface
brg_rx_en  output  1  one-cycle pulse every (active_div+1) clocks, consumed by receive
brg_tx_en  output  1  one-cycle pulse, coincident with every OVERSAMPLE-th brg_rx_en, consumed by transmit

Behaviour:
- Reset (async, rst_n=0) forces:
  - active_div = DEFAULT_DIV
  - lo_stage = DEFAULT_DIV[7:0]
  - count = DEFAULT_DIV
  - phase = 0
  - brg_rx_en = 0, brg_tx_en = 0
- Write decode:
  - wr_lo = iocs & ~iorw & (ioaddr==2'b10)
  - wr_hi = iocs & ~iorw & (ioaddr==2'b11)
  - Reads and addresses 2'b00/2'b01 are ignored by this block.
- wr_lo: lo_stage <= databus_wr. No effect on active_div, count or phase.
- wr_hi (commit):
  - active_div <= {databus_wr, lo_stage}
  - count <= {databus_wr, lo_stage}
  - phase <= 0
  - brg_rx_en <= 0 and brg_tx_en <= 0 on that edge, even if count was 0.
- Normal counting, when no wr_hi:
  - count != 0: count <= count-1, brg_rx_en <= 0.
  - count == 0: count <= active_div, brg_rx_en <= 1, phase <= phase+1 (mod OVERSAMPLE), and brg_tx_en <= (phase == OVERSAMPLE-1), else 0.
- Both outputs are registered, so each pulse is exactly 1 clock wide.
- Timing:
  - The first brg_rx_en is high in the cycle after the (active_div+1)-th rising edge following reset release or commit.
  - After that, period = active_div+1 clocks.
  - brg_tx_en period = OVERSAMPLE*(active_div+1) clocks.
  - brg_tx_en is high only when brg_rx_en is high.
- Boundary cases:
  - active_div = 0: brg_rx_en is held high every cycle; brg_tx_en pulses every 16 cycles.
  - active_div = 16'hFFFF: period is 65536 clocks; count must not overflow.
  - phase wraps from 15 to 0.
- lo_stage persists across commits. A second wr_hi without a new wr_lo reuses the previous low byte.
- Reset asserted mid-period aborts the period immediately. Outputs drop asynchronously.

Decomposition:
- Shared package spart_pkg holds:
  - ioaddr encodings: ADDR_RXTX=2'b00, ADDR_STATUS=2'b01, ADDR_DB_LO=2'b10, ADDR_DB_HI=2'b11
  - DIV_W
  - OVERSAMPLE
- These are shared with receive, transmit and the bus interface.
- No sub-module is needed. A single module holds the divisor registers, down-counter and phase counter.

Test Plan:
1. Reset with default 31, no writes -> brg_rx_en pulses every 32 clocks; brg_tx_en pulses every 512 clocks, coincident with every 16th brg_rx_en.
2. Write DB_LO=8'h45, then DB_HI=8'h01 (divisor 325) -> from the commit edge, first brg_rx_en 326 clocks later, then every 326 clocks; phase restarts, so the first brg_tx_en comes 16*326 clocks after commit.
3. Write DB_LO=8'h07 only -> period stays 32 with no glitch. Then DB_HI=8'h00 -> period becomes 8.
4. Commit DB_HI=0 with lo_stage=0 -> brg_rx_en constant 1; brg_tx_en high 1 cycle in 16.
5. wr_hi issued on the cycle count==0 -> no brg_rx_en that cycle; the next pulse comes new_div+1 clocks later.
6. Assert rst_n low mid-period with a non-default divisor -> outputs drop immediately; after release, period returns to 32 and lo_stage reads back as 8'h1F on the next lone DB_HI=0 commit (period 32).
